// File: rtl/systolic_driver_if.sv
// Handshake bundle between the host-side sequencer and systolic_driver:
// serial operand stream in, single-bit result stream out, plus abort.
interface systolic_driver_if;
  logic s_valid;
  logic s_ready;
  logic s_data;
  logic abort;
  logic r_valid;
  logic r_ready;
  logic r_data;

  // Host side: drives operands, abort and result acceptance.
  modport master (
    output s_valid, s_data, abort, r_ready,
    input  s_ready, r_valid, r_data
  );

  // Driver side: consumes operands, produces results.
  modport slave (
    input  s_valid, s_data, abort, r_ready,
    output s_ready, r_valid, r_data
  );
endinterface

// File: rtl/systolic_driver.sv
// Sequential driver for the combinational systolic array: collects
// COLUMN+ROW operand bits serially, applies them to the array as one word,
// waits SETTLE cycles, samples the array output and hands it back over a
// valid/ready result channel.
module systolic_driver #(
  parameter int ROW    = 4,
  parameter int COLUMN = 10,
  parameter int SETTLE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_driver_if.slave  bus,
  input  logic              arr_out,
  output logic [ROW-1:0]    row_drv,
  output logic [COLUMN-1:0] col_drv,
  output logic              busy
);
  localparam int N  = ROW + COLUMN;
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT    = BW'(N - 1);
  localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;
  logic [N-1:0]      sh_q, sh_d;
  logic [N-1:0]      frame;
  logic [ROW-1:0]    row_q, row_d;
  logic [COLUMN-1:0] col_q, col_d;
  logic              r_valid_q, r_valid_d;
  logic              r_data_q, r_data_d;
  logic              busy_q, busy_d;

  // Next-state logic: abort overrides everything; otherwise load, settle,
  // then hold the result until it is taken.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    settle_cnt_d = settle_cnt_q;
    sh_d         = sh_q;
    row_d        = row_q;
    col_d        = col_q;
    r_valid_d    = r_valid_q;
    r_data_d     = r_data_q;
    // Bits enter at the top and move down, so after N shifts the first bit
    // received sits at index 0 (col_drv[0]).
    frame        = {bus.s_data, sh_q[N-1:1]};

    if (bus.abort) begin
      state_d      = ST_LOAD;
      bit_cnt_d    = '0;
      settle_cnt_d = '0;
      sh_d         = '0;
      r_valid_d    = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.s_valid) begin
            sh_d = frame;
            if (bit_cnt_q == LAST_BIT) begin
              col_d        = frame[COLUMN-1:0];
              row_d        = frame[N-1:COLUMN];
              settle_cnt_d = SETTLE_INIT;
              bit_cnt_d    = '0;
              state_d      = ST_SETTLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          // Counter starts at SETTLE-1 so the sample lands SETTLE edges
          // after the final operand bit.
          if (settle_cnt_q == 8'd0) begin
            r_data_d  = arr_out;
            r_valid_d = 1'b1;
            state_d   = ST_RESULT;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        ST_RESULT: begin
          if (bus.r_ready) begin
            r_valid_d = 1'b0;
            state_d   = ST_LOAD;
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end

    busy_d = (state_d != ST_LOAD);
  end

  // State, counters, operand words and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      sh_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      r_valid_q    <= 1'b0;
      r_data_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      sh_q         <= sh_d;
      row_q        <= row_d;
      col_q        <= col_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.s_ready = (state_q == ST_LOAD);
  assign bus.r_valid = r_valid_q;
  assign bus.r_data  = r_data_q;
  assign row_drv     = row_q;
  assign col_drv     = col_q;
  assign busy        = busy_q;

endmodule

// File: doc/systolic_driver.md
Name: systolic_driver

Overview:
- Sequential driver for the combinational `systolic` array (ROW×COLUMN AND/XOR/OR grid with a single-bit output).
- Accepts operand bits serially over a valid/ready stream and assembles them into the array's row and column input words.
- Holds the words stable for a programmable settle time, samples the array output, and returns the result on a valid/ready result channel.
- Sits between the host-side stimulus sequencer and the array instance. It initiates each evaluation; the array responds.

Parameters:
- ROW, 4, array row count; width of row_drv.
- COLUMN, 10, array column count; width of col_drv.
- SETTLE, 8, cycles the driven operands are held before arr_out is sampled; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  serial operand bit valid.
- s_ready  output  1  driver accepts a bit; high only in LOAD.
- s_data  input  1  serial operand bit.
- abort  input  1  synchronous; cancels the current load or evaluation.
- row_drv  output  ROW  drives the array's inRow.
- col_drv  output  COLUMN  drives the array's inColumn.
- arr_out  input  1  array output (out).
- r_valid  output  1  result valid.
- r_ready  input  1  result consumer ready.
- r_data  output  1  sampled array output.
- busy  output  1  high in SETTLE or RESULT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to LOAD; bit counter, settle counter and shift register clear.
  - Outputs: row_drv=0, col_drv=0, r_valid=0, r_data=0, busy=0, s_ready=1 (combinational from state).
- Bit transfer: a bit is accepted on an edge where s_valid && s_ready. Gaps in s_valid are allowed and change nothing.
- Frame: N = COLUMN+ROW bits.
  - Bits 0..COLUMN-1 map to col_drv[0..COLUMN-1], LSB first.
  - Bits COLUMN..N-1 map to row_drv[0..ROW-1], LSB first.
- Shift register: bits accumulate in an internal N-bit register. row_drv and col_drv keep their previous values for the whole load.
- LOAD → SETTLE: on the edge accepting bit N-1:
  - Shift register plus that bit transfer to row_drv/col_drv.
  - Settle counter loads SETTLE-1.
  - Bit counter clears.
- SETTLE: each edge, if the settle counter is 0, then r_data ← arr_out, r_valid ← 1, state → RESULT. Otherwise the counter decrements.
- Latency: arr_out is sampled exactly SETTLE edges after the edge that accepted the last bit. With SETTLE=1, it is sampled on the next edge.
- RESULT:
  - r_valid and r_data are held stable until r_ready.
  - On the edge with r_valid && r_ready: r_valid ← 0, state → LOAD, s_ready rises in the next cycle.
  - r_data holds its last value after the handshake.
- Drive registers: row_drv/col_drv change only on the LOAD→SETTLE transfer, on reset, and never mid-evaluation.
- Backpressure: while in SETTLE or RESULT, s_ready=0 and s_data is ignored.
- abort (any state, synchronous, priority over all other events in the same cycle):
  - State → LOAD; bit and settle counters clear; r_valid ← 0.
  - Shift-register contents are discarded.
  - row_drv, col_drv and r_data keep their values.
  - A bit presented in the abort cycle is not accepted.
- Reset mid-operation: immediate return to reset values, regardless of state.
- busy = (state != LOAD), registered with the state.

Test Plan:
1. Reset mid-load: 7 bits accepted, assert rst_n=0 → s_ready=1, row_drv=0, col_drv=0, r_valid=0. A fresh 14-bit frame then completes normally.
2. Bit ordering, arr_out tied to bench stub: frame of bit0=1 then 13 zeros → col_drv=10'h001, row_drv=4'h0. Frame with only bit13=1 → row_drv=4'h8, col_drv=0.
3. Latency, SETTLE=8, real systolic instance: all-ones frame → row_drv=4'hF, col_drv=10'h3FF, r_valid rises 8 edges after the last accepted bit, r_data=1. All-zeros frame → r_data=0.
4. Backpressure: hold r_ready=0 for 5 cycles after r_valid, drive s_valid=1 → r_valid/r_data stable, s_ready=0, no bits accepted. Raise r_ready → r_valid=0 next cycle, s_ready=1.
5. Gapped input: toggle s_valid every other cycle across a 14-bit frame → same drive values and result as the ungapped frame. row_drv/col_drv unchanged until bit 13 is accepted.
6. Abort: assert abort during SETTLE (cnt=3) → no r_valid, state LOAD, drive values retained. Assert abort during RESULT → r_valid drops next edge, r_data unchanged.
